axi4_burst_ram: RTL and testbench

Parametrised AXI4 full-protocol slave memory. It is the successor to the fixed single-beat memory block behind `memory_block_wrapper`, and it sits directly on an interconnect master port as accelerator scratchpad or weight store. It adds the following over the previous block:

- INCR, FIXED and WRAP bursts of up to 256 beats.
- Byte strobes, ID echo and SLVERR reporting.
- Independent read and write channels that run concurrently at one beat per cycle.

---
 rtl/axi4_burst_ram.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_axi4_burst_ram.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_ram.sv
// AXI4 slave scratchpad memory: INCR/FIXED/WRAP bursts up to 256 beats, byte strobes,
// independent read and write channels, SLVERR on bad bursts or out-of-range beats.
module axi4_burst_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 1024,
    parameter int ID_W   = 4
) (
    input  logic                  sys_clock,
    input  logic                  reset_rtl_n,
    input  logic [ID_W-1:0]       S_AXI_awid,
    input  logic [ADDR_W-1:0]     S_AXI_awaddr,
    input  logic [7:0]            S_AXI_awlen,
    input  logic [2:0]            S_AXI_awsize,
    input  logic [1:0]            S_AXI_awburst,
    input  logic                  S_AXI_awvalid,
    output logic                  S_AXI_awready,
    input  logic [DATA_W-1:0]     S_AXI_wdata,
    input  logic [DATA_W/8-1:0]   S_AXI_wstrb,
    input  logic                  S_AXI_wlast,
    input  logic                  S_AXI_wvalid,
    output logic                  S_AXI_wready,
    output logic [ID_W-1:0]       S_AXI_bid,
    output logic [1:0]            S_AXI_bresp,
    output logic                  S_AXI_bvalid,
    input  logic                  S_AXI_bready,
    input  logic [ID_W-1:0]       S_AXI_arid,
    input  logic [ADDR_W-1:0]     S_AXI_araddr,
    input  logic [7:0]            S_AXI_arlen,
    input  logic [2:0]            S_AXI_arsize,
    input  logic [1:0]            S_AXI_arburst,
    input  logic                  S_AXI_arvalid,
    output logic                  S_AXI_arready,
    output logic [ID_W-1:0]       S_AXI_rid,
    output logic [DATA_W-1:0]     S_AXI_rdata,
    output logic [1:0]            S_AXI_rresp,
    output logic                  S_AXI_rlast,
    output logic                  S_AXI_rvalid,
    input  logic                  S_AXI_rready
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int AXW   = ADDR_W + 1;
    localparam int MIW   = $clog2(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [7:0] len);
        return (size != 3'(OFF)) || (burst == 2'b11) ||
               ((burst == 2'b10) && !wrap_len_ok(len));
    endfunction

    // Addresses carry one extra bit so an INCR running off the top is seen as out of range
    // instead of aliasing back to word 0.
    function automatic logic beat_bad(input logic [AXW-1:0] addr, input logic [2:0] size);
        return (32'(addr[AXW-1:OFF]) >= $unsigned(DEPTH)) || (size != 3'(OFF));
    endfunction

    function automatic logic [AXW-1:0] next_addr(input logic [AXW-1:0] addr,
                                                 input logic [1:0] burst,
                                                 input logic [7:0] len);
        logic [AXW-1:0] incr;
        logic [AXW-1:0] mask;
        incr = addr + AXW'(BYTES);
        mask = AXW'(len) << OFF;
        if (burst == 2'b00) begin
            return addr;
        end else if ((burst == 2'b10) && wrap_len_ok(len)) begin
            return (addr & ~mask) | (incr & mask);
        end
        return incr;
    endfunction

    // Holds the address-channel readies low until the first edge after reset release.
    logic up_q, up_d;

    w_state_e          w_state_q, w_state_d;
    logic [ID_W-1:0]   w_id_q, w_id_d;
    logic [AXW-1:0]    w_addr_q, w_addr_d;
    logic [7:0]        w_len_q, w_len_d;
    logic [2:0]        w_size_q, w_size_d;
    logic [1:0]        w_burst_q, w_burst_d;
    logic [7:0]        w_cnt_q, w_cnt_d;
    logic              w_err_q, w_err_d;

    r_state_e          r_state_q, r_state_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic [AXW-1:0]    r_addr_q, r_addr_d;
    logic [7:0]        r_len_q, r_len_d;
    logic [2:0]        r_size_q, r_size_d;
    logic [1:0]        r_burst_q, r_burst_d;
    logic [7:0]        r_cnt_q, r_cnt_d;
    logic              r_done_q, r_done_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic aw_hs, w_hs, w_last_beat, w_bad, mem_we;
    logic ar_hs, r_hs, r_fetch, r_bad;

    assign up_d        = 1'b1;
    assign aw_hs       = S_AXI_awvalid && S_AXI_awready;
    assign w_hs        = S_AXI_wvalid && S_AXI_wready;
    assign w_last_beat = (w_cnt_q == w_len_q);
    assign w_bad       = beat_bad(w_addr_q, w_size_q);
    assign mem_we      = w_hs && !w_bad;
    assign ar_hs       = S_AXI_arvalid && S_AXI_arready;
    assign r_hs        = rvalid_q && S_AXI_rready;
    assign r_fetch     = (r_state_q == R_DATA) && !r_done_q && (!rvalid_q || S_AXI_rready);
    assign r_bad       = beat_bad(r_addr_q, r_size_q);

    always_ff @(posedge sys_clock or negedge reset_rtl_n) begin
        if (!reset_rtl_n) begin
            up_q      <= 1'b0;
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            up_q      <= up_d;
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_state_d = W_RESP;
            W_RESP:  if (S_AXI_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_awready = up_q && (w_state_q == W_IDLE);
        S_AXI_wready  = (w_state_q == W_DATA);
        S_AXI_bvalid  = (w_state_q == W_RESP);
        S_AXI_bid     = w_id_q;
        S_AXI_bresp   = ((w_state_q == W_RESP) && w_err_q) ? 2'b10 : 2'b00;
    end

    always_comb begin
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        if (aw_hs) begin
            w_id_d    = S_AXI_awid;
            w_addr_d  = {1'b0, S_AXI_awaddr};
            w_len_d   = S_AXI_awlen;
            w_size_d  = S_AXI_awsize;
            w_burst_d = S_AXI_awburst;
            w_cnt_d   = 8'd0;
            w_err_d   = 1'b0;
        end
        if (w_hs) begin
            w_addr_d = next_addr(w_addr_q, w_burst_q, w_len_q);
            w_cnt_d  = w_cnt_q + 8'd1;
            w_err_d  = w_err_q || w_bad || burst_err(w_size_q, w_burst_q, w_len_q) ||
                       (S_AXI_wlast != w_last_beat);
        end
    end

    always_ff @(posedge sys_clock or negedge reset_rtl_n) begin
        if (!reset_rtl_n) begin
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (S_AXI_wstrb[b]) mem[w_addr_q[OFF +: MIW]][8*b +: 8] <= S_AXI_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (r_hs && rlast_q) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_arready = up_q && (r_state_q == R_IDLE);
        S_AXI_rid     = r_id_q;
        S_AXI_rdata   = rdata_q;
        S_AXI_rresp   = rresp_q;
        S_AXI_rlast   = rlast_q;
        S_AXI_rvalid  = rvalid_q;
    end

    // The array is read combinationally ahead of the edge, so a same-cycle write is not seen.
    always_comb begin
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        r_done_d  = r_done_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        if (ar_hs) begin
            r_id_d    = S_AXI_arid;
            r_addr_d  = {1'b0, S_AXI_araddr};
            r_len_d   = S_AXI_arlen;
            r_size_d  = S_AXI_arsize;
            r_burst_d = S_AXI_arburst;
            r_cnt_d   = 8'd0;
            r_done_d  = 1'b0;
        end
        if (r_fetch) begin
            rdata_d  = r_bad ? '0 : mem[r_addr_q[OFF +: MIW]];
            rvalid_d = 1'b1;
            rlast_d  = (r_cnt_q == r_len_q);
            rresp_d  = (r_bad || burst_err(r_size_q, r_burst_q, r_len_q)) ? 2'b10 : 2'b00;
            r_addr_d = next_addr(r_addr_q, r_burst_q, r_len_q);
            r_cnt_d  = r_cnt_q + 8'd1;
            r_done_d = (r_cnt_q == r_len_q);
        end else if (r_hs) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            rresp_d  = 2'b00;
        end
    end

    always_ff @(posedge sys_clock or negedge reset_rtl_n) begin
        if (!reset_rtl_n) begin
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_cnt_q   <= '0;
            r_done_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            r_done_q  <= r_done_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axi4_burst_ram.sv
// Directed bench for axi4_burst_ram: per-scenario tasks with hand-computed expectations.
module tb_axi4_burst_ram;

    localparam int LIM = 200;

    logic        sys_clock;
    logic        reset_rtl_n;
    logic [3:0]  S_AXI_awid;
    logic [11:0] S_AXI_awaddr;
    logic [7:0]  S_AXI_awlen;
    logic [2:0]  S_AXI_awsize;
    logic [1:0]  S_AXI_awburst;
    logic        S_AXI_awvalid;
    logic        S_AXI_awready;
    logic [31:0] S_AXI_wdata;
    logic [3:0]  S_AXI_wstrb;
    logic        S_AXI_wlast;
    logic        S_AXI_wvalid;
    logic        S_AXI_wready;
    logic [3:0]  S_AXI_bid;
    logic [1:0]  S_AXI_bresp;
    logic        S_AXI_bvalid;
    logic        S_AXI_bready;
    logic [3:0]  S_AXI_arid;
    logic [11:0] S_AXI_araddr;
    logic [7:0]  S_AXI_arlen;
    logic [2:0]  S_AXI_arsize;
    logic [1:0]  S_AXI_arburst;
    logic        S_AXI_arvalid;
    logic        S_AXI_arready;
    logic [3:0]  S_AXI_rid;
    logic [31:0] S_AXI_rdata;
    logic [1:0]  S_AXI_rresp;
    logic        S_AXI_rlast;
    logic        S_AXI_rvalid;
    logic        S_AXI_rready;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] wbuf [256];
    logic [3:0]  sbuf [256];
    logic [31:0] rd_data [256];
    logic [1:0]  rd_resp [256];
    logic        rd_last [256];
    logic [3:0]  rd_id;
    int          rd_lat, rd_cycles;
    logic        rd_held_bad;
    logic [1:0]  wr_bresp;
    logic [3:0]  wr_bid;
    int          wr_cycles, wr_blat;

    axi4_burst_ram #(.DATA_W(32), .ADDR_W(12), .DEPTH(1024), .ID_W(4)) dut (
        .sys_clock(sys_clock), .reset_rtl_n(reset_rtl_n),
        .S_AXI_awid(S_AXI_awid), .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awlen(S_AXI_awlen),
        .S_AXI_awsize(S_AXI_awsize), .S_AXI_awburst(S_AXI_awburst),
        .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready),
        .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb), .S_AXI_wlast(S_AXI_wlast),
        .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready),
        .S_AXI_bid(S_AXI_bid), .S_AXI_bresp(S_AXI_bresp), .S_AXI_bvalid(S_AXI_bvalid),
        .S_AXI_bready(S_AXI_bready),
        .S_AXI_arid(S_AXI_arid), .S_AXI_araddr(S_AXI_araddr), .S_AXI_arlen(S_AXI_arlen),
        .S_AXI_arsize(S_AXI_arsize), .S_AXI_arburst(S_AXI_arburst),
        .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
        .S_AXI_rid(S_AXI_rid), .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp),
        .S_AXI_rlast(S_AXI_rlast), .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    // Drives one write burst from wbuf/sbuf; inputs change on the falling edge only.
    task automatic write_burst(input logic [3:0] id, input logic [11:0] addr,
                               input logic [7:0] len, input logic [1:0] burst,
                               input logic bad_last);
        int n;
        S_AXI_awid = id; S_AXI_awaddr = addr; S_AXI_awlen = len;
        S_AXI_awsize = 3'd2; S_AXI_awburst = burst; S_AXI_awvalid = 1'b1;
        n = 0;
        while (!S_AXI_awready && n < LIM) begin @(negedge sys_clock); n++; end
        if (n >= LIM) begin
            miscompares++;
            $display("[TB] FAIL aw_timeout: awready=%b, required 1 within %0d cycles", S_AXI_awready, LIM);
        end
        @(negedge sys_clock);
        S_AXI_awvalid = 1'b0;
        wr_cycles = 0;
        for (int i = 0; i <= int'(len); i++) begin
            S_AXI_wdata = wbuf[i]; S_AXI_wstrb = sbuf[i];
            S_AXI_wlast = bad_last ? (i == 0) : (i == int'(len));
            S_AXI_wvalid = 1'b1;
            n = 0;
            while (!S_AXI_wready && n < LIM) begin @(negedge sys_clock); n++; end
            wr_cycles += n;
            @(negedge sys_clock);
            wr_cycles++;
        end
        S_AXI_wvalid = 1'b0; S_AXI_wlast = 1'b0;
        S_AXI_bready = 1'b1;
        n = 0;
        while (!S_AXI_bvalid && n < LIM) begin @(negedge sys_clock); n++; end
        if (n >= LIM) begin
            miscompares++;
            $display("[TB] FAIL b_timeout: bvalid=%b, required 1 within %0d cycles", S_AXI_bvalid, LIM);
        end
        wr_blat = n; wr_bresp = S_AXI_bresp; wr_bid = S_AXI_bid;
        @(negedge sys_clock);
        S_AXI_bready = 1'b0;
    endtask

    // Collects a read burst into rd_*; with toggle set, rready alternates starting low.
    task automatic read_burst(input logic [3:0] id, input logic [11:0] addr,
                              input logic [7:0] len, input logic [1:0] burst,
                              input logic toggle);
        int n, got, cyc;
        logic stalled;
        logic [31:0] sv_data;
        logic [1:0] sv_resp;
        logic sv_last;
        S_AXI_arid = id; S_AXI_araddr = addr; S_AXI_arlen = len;
        S_AXI_arsize = 3'd2; S_AXI_arburst = burst; S_AXI_arvalid = 1'b1;
        S_AXI_rready = 1'b0;
        n = 0;
        while (!S_AXI_arready && n < LIM) begin @(negedge sys_clock); n++; end
        if (n >= LIM) begin
            miscompares++;
            $display("[TB] FAIL ar_timeout: arready=%b, required 1 within %0d cycles", S_AXI_arready, LIM);
        end
        @(negedge sys_clock);
        S_AXI_arvalid = 1'b0;
        rd_lat = 0;
        while (!S_AXI_rvalid && rd_lat < LIM) begin @(negedge sys_clock); rd_lat++; end
        got = 0; cyc = 0; stalled = 1'b0; rd_held_bad = 1'b0;
        sv_data = '0; sv_resp = '0; sv_last = 1'b0;
        while (got <= int'(len) && cyc < LIM) begin
            S_AXI_rready = toggle ? ((cyc % 2) == 1) : 1'b1;
            if (stalled && (!S_AXI_rvalid || S_AXI_rdata !== sv_data ||
                            S_AXI_rresp !== sv_resp || S_AXI_rlast !== sv_last))
                rd_held_bad = 1'b1;
            if (S_AXI_rvalid && S_AXI_rready) begin
                rd_data[got] = S_AXI_rdata; rd_resp[got] = S_AXI_rresp;
                rd_last[got] = S_AXI_rlast; rd_id = S_AXI_rid;
                got++; stalled = 1'b0;
            end else if (S_AXI_rvalid) begin
                stalled = 1'b1; sv_data = S_AXI_rdata; sv_resp = S_AXI_rresp; sv_last = S_AXI_rlast;
            end else begin
                stalled = 1'b0;
            end
            @(negedge sys_clock);
            cyc++;
        end
        S_AXI_rready = 1'b0;
        rd_cycles = cyc;
        if (got <= int'(len)) begin
            miscompares++;
            $display("[TB] FAIL r_timeout: got %0d beats, required %0d", got, int'(len) + 1);
        end
    endtask

    task automatic test_reset();
        reset_rtl_n = 1'b0;
        repeat (3) @(negedge sys_clock);
        vectors++;
        if ({S_AXI_awready, S_AXI_wready, S_AXI_bvalid, S_AXI_bresp, S_AXI_bid, S_AXI_arready,
             S_AXI_rvalid, S_AXI_rlast, S_AXI_rresp, S_AXI_rid, S_AXI_rdata} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: aw=%b w=%b b=%b ar=%b rv=%b rdata=%h, required all 0",
                     S_AXI_awready, S_AXI_wready, S_AXI_bvalid, S_AXI_arready, S_AXI_rvalid, S_AXI_rdata);
        end
        reset_rtl_n = 1'b1;
        #1;
        vectors++;
        if (S_AXI_awready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL awready_at_release: got %b required 0", S_AXI_awready);
        end
        @(negedge sys_clock);
        vectors++;
        if ({S_AXI_awready, S_AXI_arready} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL ready_after_reset: got %b required 11", {S_AXI_awready, S_AXI_arready});
        end
    endtask

    task automatic test_single();
        wbuf[0] = 32'hDEADBEEF;
        write_burst(4'd5, 12'h100, 8'd0, 2'b01, 1'b0);
        vectors++;
        if ({wr_bresp, wr_bid} !== {2'b00, 4'd5}) begin
            miscompares++;
            $display("[TB] FAIL single_b: got resp=%b id=%0d required resp=00 id=5", wr_bresp, wr_bid);
        end
        read_burst(4'd9, 12'h100, 8'd0, 2'b01, 1'b0);
        vectors++;
        if (rd_data[0] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL single_rdata: got %h required deadbeef", rd_data[0]);
        end
        vectors++;
        if ({rd_last[0], rd_resp[0], rd_id} !== {1'b1, 2'b00, 4'd9}) begin
            miscompares++;
            $display("[TB] FAIL single_rflags: got last=%b resp=%b id=%0d required 1/00/9",
                     rd_last[0], rd_resp[0], rd_id);
        end
        vectors++;
        if (rd_lat !== 1) begin
            miscompares++;
            $display("[TB] FAIL single_rlatency: got %0d cycles required 1", rd_lat);
        end
    endtask

    task automatic test_strobes();
        wbuf[0] = 32'h11223344;
        write_burst(4'd1, 12'h040, 8'd0, 2'b01, 1'b0);
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
        write_burst(4'd1, 12'h040, 8'd0, 2'b01, 1'b0);
        sbuf[0] = 4'hF;
        read_burst(4'd1, 12'h040, 8'd0, 2'b01, 1'b0);
        vectors++;
        if (rd_data[0] !== 32'h11BB33DD) begin
            miscompares++;
            $display("[TB] FAIL strobe_merge: got %h required 11bb33dd", rd_data[0]);
        end
    endtask

    task automatic test_incr_backpressure();
        for (int i = 0; i < 8; i++) wbuf[i] = 32'(i + 1);
        write_burst(4'd2, 12'h200, 8'd7, 2'b01, 1'b0);
        vectors++;
        if (wr_bresp !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL incr_bresp: got %b required 00", wr_bresp);
        end
        read_burst(4'd2, 12'h200, 8'd7, 2'b01, 1'b1);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({rd_data[i], rd_last[i]} !== {32'(i + 1), (i == 7)}) begin
                miscompares++;
                $display("[TB] FAIL incr_beat%0d: got data=%h last=%b required %h/%b",
                         i, rd_data[i], rd_last[i], 32'(i + 1), (i == 7));
            end
        end
        vectors++;
        if (rd_held_bad !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL incr_hold: got unstable=%b required 0", rd_held_bad);
        end
    endtask

    task automatic test_wrap();
        wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
        write_burst(4'd3, 12'h308, 8'd3, 2'b10, 1'b0);
        vectors++;
        if (wr_bresp !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL wrap_bresp: got %b required 00", wr_bresp);
        end
        read_burst(4'd3, 12'h300, 8'd3, 2'b01, 1'b0);
        vectors++;
        if ({rd_data[0], rd_data[1], rd_data[2], rd_data[3]} !== {32'hC, 32'hD, 32'hA, 32'hB}) begin
            miscompares++;
            $display("[TB] FAIL wrap_layout: got %h %h %h %h required c d a b",
                     rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
        end
        read_burst(4'd3, 12'h308, 8'd3, 2'b10, 1'b0);
        vectors++;
        if ({rd_data[0], rd_data[3], rd_resp[3]} !== {32'hA, 32'hD, 2'b00}) begin
            miscompares++;
            $display("[TB] FAIL wrap_read: got first=%h last=%h resp=%b required a/d/00",
                     rd_data[0], rd_data[3], rd_resp[3]);
        end
        write_burst(4'd3, 12'h320, 8'd2, 2'b10, 1'b0);
        vectors++;
        if (wr_bresp !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL wrap_len2_bresp: got %b required 10", wr_bresp);
        end
    endtask

    task automatic test_out_of_range();
        wbuf[0] = 32'h0BADF00D;
        write_burst(4'd4, 12'h000, 8'd0, 2'b01, 1'b0);
        wbuf[0] = 32'h12345678; wbuf[1] = 32'h99999999;
        write_burst(4'd4, 12'hFFC, 8'd1, 2'b01, 1'b0);
        vectors++;
        if (wr_bresp !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL oob_bresp: got %b required 10", wr_bresp);
        end
        read_burst(4'd4, 12'hFFC, 8'd1, 2'b01, 1'b0);
        vectors++;
        if ({rd_data[0], rd_resp[0]} !== {32'h12345678, 2'b00}) begin
            miscompares++;
            $display("[TB] FAIL oob_beat0: got %h/%b required 12345678/00", rd_data[0], rd_resp[0]);
        end
        vectors++;
        if ({rd_data[1], rd_resp[1], rd_last[1]} !== {32'h0, 2'b10, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL oob_beat1: got %h/%b/%b required 00000000/10/1",
                     rd_data[1], rd_resp[1], rd_last[1]);
        end
        read_burst(4'd4, 12'h000, 8'd0, 2'b01, 1'b0);
        vectors++;
        if (rd_data[0] !== 32'h0BADF00D) begin
            miscompares++;
            $display("[TB] FAIL oob_no_alias: got %h required 0badf00d", rd_data[0]);
        end
    endtask

    task automatic test_bad_wlast();
        wbuf[0] = 32'h77; wbuf[1] = 32'h78;
        write_burst(4'd6, 12'h700, 8'd1, 2'b01, 1'b1);
        vectors++;
        if (wr_bresp !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL badlast_bresp: got %b required 10", wr_bresp);
        end
        read_burst(4'd6, 12'h700, 8'd1, 2'b01, 1'b0);
        vectors++;
        if ({rd_data[0], rd_data[1], rd_resp[1]} !== {32'h77, 32'h78, 2'b00}) begin
            miscompares++;
            $display("[TB] FAIL badlast_data: got %h %h/%b required 77 78/00",
                     rd_data[0], rd_data[1], rd_resp[1]);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h100 + 32'(i);
        write_burst(4'd7, 12'h400, 8'd7, 2'b01, 1'b0);
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h200 + 32'(i);
        fork
            write_burst(4'd7, 12'h400, 8'd7, 2'b01, 1'b0);
            read_burst(4'd8, 12'h400, 8'd7, 2'b01, 1'b0);
        join
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (rd_data[i] !== 32'h100 + 32'(i)) begin
                miscompares++;
                $display("[TB] FAIL overlap_old%0d: got %h required %h", i, rd_data[i], 32'h100 + 32'(i));
            end
        end
        vectors++;
        if ({rd_cycles, wr_cycles, wr_blat} !== {32'd8, 32'd8, 32'd0}) begin
            miscompares++;
            $display("[TB] FAIL overlap_rate: got r=%0d w=%0d blat=%0d required 8/8/0",
                     rd_cycles, wr_cycles, wr_blat);
        end
        read_burst(4'd8, 12'h400, 8'd7, 2'b01, 1'b0);
        vectors++;
        if ({rd_data[0], rd_data[7]} !== {32'h200, 32'h207}) begin
            miscompares++;
            $display("[TB] FAIL overlap_new: got %h %h required 200 207", rd_data[0], rd_data[7]);
        end
    endtask

    task automatic test_reset_mid_write();
        int n;
        S_AXI_awid = 4'd2; S_AXI_awaddr = 12'h500; S_AXI_awlen = 8'd3;
        S_AXI_awsize = 3'd2; S_AXI_awburst = 2'b01; S_AXI_awvalid = 1'b1;
        n = 0;
        while (!S_AXI_awready && n < LIM) begin @(negedge sys_clock); n++; end
        @(negedge sys_clock);
        S_AXI_awvalid = 1'b0;
        S_AXI_wstrb = 4'hF; S_AXI_wlast = 1'b0; S_AXI_wvalid = 1'b1;
        S_AXI_wdata = 32'h55; @(negedge sys_clock);
        S_AXI_wdata = 32'h66; @(negedge sys_clock);
        S_AXI_wdata = 32'h77;
        reset_rtl_n = 1'b0;
        #1;
        vectors++;
        if ({S_AXI_awready, S_AXI_wready, S_AXI_bvalid, S_AXI_bid, S_AXI_arready, S_AXI_rvalid} !== '0) begin
            miscompares++;
            $display("[TB] FAIL midreset_outputs: aw=%b w=%b b=%b bid=%0d ar=%b rv=%b required all 0",
                     S_AXI_awready, S_AXI_wready, S_AXI_bvalid, S_AXI_bid, S_AXI_arready, S_AXI_rvalid);
        end
        S_AXI_wvalid = 1'b0;
        @(negedge sys_clock); @(negedge sys_clock);
        reset_rtl_n = 1'b1;
        @(negedge sys_clock);
        read_burst(4'd1, 12'h500, 8'd2, 2'b01, 1'b0);
        vectors++;
        if ({rd_data[0], rd_data[1]} !== {32'h55, 32'h66}) begin
            miscompares++;
            $display("[TB] FAIL midreset_kept: got %h %h required 55 66", rd_data[0], rd_data[1]);
        end
        wbuf[0] = 32'h600D;
        write_burst(4'd11, 12'h600, 8'd0, 2'b01, 1'b0);
        vectors++;
        if ({wr_bresp, wr_bid} !== {2'b00, 4'd11}) begin
            miscompares++;
            $display("[TB] FAIL midreset_next_aw: got resp=%b id=%0d required 00/11", wr_bresp, wr_bid);
        end
    endtask

    initial begin
        S_AXI_awid = '0; S_AXI_awaddr = '0; S_AXI_awlen = '0; S_AXI_awsize = 3'd2;
        S_AXI_awburst = 2'b01; S_AXI_awvalid = 1'b0;
        S_AXI_wdata = '0; S_AXI_wstrb = '0; S_AXI_wlast = 1'b0; S_AXI_wvalid = 1'b0;
        S_AXI_bready = 1'b0;
        S_AXI_arid = '0; S_AXI_araddr = '0; S_AXI_arlen = '0; S_AXI_arsize = 3'd2;
        S_AXI_arburst = 2'b01; S_AXI_arvalid = 1'b0; S_AXI_rready = 1'b0;
        for (int i = 0; i < 256; i++) begin wbuf[i] = '0; sbuf[i] = 4'hF; end
        test_reset();
        test_single();
        test_strobes();
        test_incr_backpressure();
        test_wrap();
        test_out_of_range();
        test_bad_wlast();
        test_back_to_back();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
